sw_debounce: RTL and testbench

- Synchronises and debounces raw board switch/button inputs before they reach the SoC's `switch` / `btn_*` inputs in the board top.
- Sits directly upstream of the SoC instance; board pins go in, clean levels plus one-cycle edge pulses come out.
- Per-bit 2-flop synchroniser, per-bit stability counter, optional polarity inversion. The inversion replaces the ad-hoc `~SW` at the top level.

---
 rtl/sw_debounce.sv | 101 ++++++++++
 tb/tb_sw_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Synchroniser and debouncer for raw board switches and buttons. It sits
// between the board pins and the SoC's switch/button inputs. Each bit has its
// own path: optional polarity inversion, a 2-flop synchroniser, and a
// stability counter. The debounced level follows the synchronised input only
// after the input has disagreed with it for STABLE_CYCLES consecutive cycles.
// A change of the debounced level also emits a one-cycle rise or fall pulse.
//
// Ports:
//   clk        in   1      system clock; all logic runs on the rising edge
//   resetn     in   1      synchronous active-low reset
//   raw_in     in   WIDTH  asynchronous board inputs
//   db_out     out  WIDTH  debounced level
//   rise       out  WIDTH  one-cycle pulse when db_out[i] goes 0->1
//   fall       out  WIDTH  one-cycle pulse when db_out[i] goes 1->0
//   any_change out  1      OR of all rise|fall bits, in the same cycle
//
// Every output comes from a register. No combinational path runs from raw_in
// to any output.
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000,
    parameter bit INVERT        = 1'b0,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // Counter value on which the debounced level flips. The counter stops
    // here, so it can never wrap.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] cond_in;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Active-low board switches are flipped here, so the rest of the
    // design always works on active-high levels.
    assign cond_in = INVERT ? ~raw_in : raw_in;

    // Next-state logic for each bit. This logic reads only s2 and never the
    // first synchroniser stage.
    always_comb begin
        db_next   = db_out;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != db_out[i]) begin
                if (cnt[i] == LAST) begin
                    db_next[i]   = s2[i];
                    rise_next[i] = s2[i];
                    fall_next[i] = ~s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
            // When s2 agrees with db_out, the count returns to zero. A glitch
            // therefore throws away all the progress made so far.
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1         <= '0;
            s2         <= '0;
            db_out     <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= cond_in;
            s2         <= s1;
            db_out     <= db_next;
            rise       <= rise_next;
            fall       <= fall_next;
            any_change <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//
// Three instances of sw_debounce:
//   0: STABLE_CYCLES=4, INVERT=0  (main scenarios)
//   1: STABLE_CYCLES=4, INVERT=1  (active-low board switches)
//   2: STABLE_CYCLES=1, INVERT=0  (minimum threshold)
//
// When the driver applies a stimulus, it pushes the expected pulse event
// (cycle, db_out, rise, fall) into that instance's queue. A monitor runs on
// the falling edge. On each any_change it pops one event and compares it with
// the outputs. It also checks the pulse invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  db;
        logic [7:0]  rs;
        logic [7:0]  fl;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] cyc = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- DUTs ----------------
    logic [7:0] raw_main = 8'h00;
    logic [7:0] raw_inv  = 8'hFF;
    logic [7:0] raw_s1   = 8'h00;

    logic [7:0] db_w   [3];
    logic [7:0] rise_w [3];
    logic [7:0] fall_w [3];
    logic       any_w  [3];

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(4), .INVERT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .raw_in(raw_main),
        .db_out(db_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .any_change(any_w[0])
    );

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(4), .INVERT(1'b1)) dut_inv (
        .clk(clk), .resetn(resetn), .raw_in(raw_inv),
        .db_out(db_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .any_change(any_w[1])
    );

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(1), .INVERT(1'b0)) dut_s1 (
        .clk(clk), .resetn(resetn), .raw_in(raw_s1),
        .db_out(db_w[2]), .rise(rise_w[2]), .fall(fall_w[2]), .any_change(any_w[2])
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    task automatic push_exp(input int k, input logic [31:0] at,
                            input logic [7:0] d, input logic [7:0] r,
                            input logic [7:0] f);
        exp_t e;
        e = '{cyc: at, db: d, rs: r, fl: f};
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                e    = '0;

                checks++;
                if ((rise_w[k] & fall_w[k]) != 8'h00) begin
                    failures++;
                    $display("FAIL rise_fall_overlap dut%0d cyc=%0d rise=%h fall=%h", k, cyc, rise_w[k], fall_w[k]);
                end
                checks++;
                if (any_w[k] !== |(rise_w[k] | fall_w[k])) begin
                    failures++;
                    $display("FAIL any_change dut%0d cyc=%0d got=%b rise=%h fall=%h", k, cyc, any_w[k], rise_w[k], fall_w[k]);
                end

                if (any_w[k] === 1'b1) begin
                    case (k)
                        0: if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                        1: if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                        default: if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); have = 1'b1; end
                    endcase
                    checks++;
                    if (!have) begin
                        failures++;
                        $display("FAIL unexpected_pulse dut%0d cyc=%0d db=%h rise=%h fall=%h", k, cyc, db_w[k], rise_w[k], fall_w[k]);
                    end else if (e.cyc != cyc || e.db !== db_w[k] ||
                                 e.rs !== rise_w[k] || e.fl !== fall_w[k]) begin
                        failures++;
                        $display("FAIL pulse_event dut%0d got cyc=%0d db=%h rise=%h fall=%h exp cyc=%0d db=%h rise=%h fall=%h",
                                 k, cyc, db_w[k], rise_w[k], fall_w[k], e.cyc, e.db, e.rs, e.fl);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_db(input string name, input int k, input logic [7:0] exp);
        checks++;
        if (db_w[k] !== exp) begin
            failures++;
            $display("FAIL %s dut%0d db_out got=%h exp=%h", name, k, db_w[k], exp);
        end
    endtask

    task automatic check_reset_state(input int k);
        checks++;
        if (db_w[k] !== 8'h00 || rise_w[k] !== 8'h00 || fall_w[k] !== 8'h00 || any_w[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dut%0d got db=%h rise=%h fall=%h any=%b exp all 0",
                     k, db_w[k], rise_w[k], fall_w[k], any_w[k]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset: all outputs must be zero.
        resetn = 1'b0;
        step(2);
        for (int k = 0; k < 3; k++) check_reset_state(k);
        mon_en = 1'b1;
        resetn = 1'b1;

        // Idle on 0x00: no pulses, and db_out stays 0.
        step(20);
        check_db("idle", 0, 8'h00);
        check_db("inv_idle", 1, 8'h00);

        // Single rise: the change lands 6 edges after the drive point.
        raw_main = 8'h01;
        push_exp(0, cyc + 32'd6, 8'h01, 8'h01, 8'h00);
        step(10);
        check_db("rise_bit0", 0, 8'h01);

        // Return to 0 produces a fall.
        raw_main = 8'h00;
        push_exp(0, cyc + 32'd6, 8'h00, 8'h00, 8'h01);
        step(10);
        check_db("fall_bit0", 0, 8'h00);

        // A 3-cycle glitch is rejected.
        raw_main = 8'h01;
        step(3);
        raw_main = 8'h00;
        step(10);
        check_db("glitch3", 0, 8'h00);

        // A 4-cycle pulse just reaches the threshold. It rises, then falls back.
        raw_main = 8'h01;
        push_exp(0, cyc + 32'd6, 8'h01, 8'h01, 8'h00);
        step(4);
        raw_main = 8'h00;
        push_exp(0, cyc + 32'd6, 8'h00, 8'h00, 8'h01);
        step(12);
        check_db("pulse4", 0, 8'h00);

        // Simultaneous rises and falls on several bits.
        raw_main = 8'h0F;
        push_exp(0, cyc + 32'd6, 8'h0F, 8'h0F, 8'h00);
        step(10);
        check_db("low_nibble", 0, 8'h0F);
        raw_main = 8'hF0;
        push_exp(0, cyc + 32'd6, 8'hF0, 8'hF0, 8'h0F);
        step(10);
        check_db("swap_nibble", 0, 8'hF0);

        // Reset while db_out=0xF0 clears it without a pulse.
        resetn   = 1'b0;
        raw_main = 8'h00;
        step(2);
        resetn = 1'b1;
        step(3);
        check_db("reset_clear", 0, 8'h00);

        // A reset in the middle of a count discards the progress made so far.
        raw_main = 8'hFF;
        step(3);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        push_exp(0, cyc + 32'd6, 8'hFF, 8'hFF, 8'h00);
        step(5);
        check_db("midreset_hold", 0, 8'h00);
        step(5);
        check_db("midreset_done", 0, 8'hFF);

        // Inverted instance: 0xFF has read as 0x00 all along. Now 0xFE.
        check_db("inv_held_ff", 1, 8'h00);
        raw_inv = 8'hFE;
        push_exp(1, cyc + 32'd6, 8'h01, 8'h01, 8'h00);
        step(10);
        check_db("inv_rise", 1, 8'h01);

        // STABLE_CYCLES=1: 3-edge latency. A 1-cycle input still passes.
        raw_s1 = 8'h05;
        push_exp(2, cyc + 32'd3, 8'h05, 8'h05, 8'h00);
        step(1);
        raw_s1 = 8'h00;
        push_exp(2, cyc + 32'd3, 8'h00, 8'h00, 8'h05);
        step(6);
        check_db("s1_back", 2, 8'h00);

        step(2);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0 || exp_q2.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses left q0=%0d q1=%0d q2=%0d exp 0",
                     exp_q0.size(), exp_q1.size(), exp_q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
